// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: default widths,
// HALT opcode and its field position, and the sequencer state encoding.
package fetch_pkg;

  localparam int DEFAULT_PC_W    = 8;
  localparam int DEFAULT_INSTR_W = 24;

  localparam logic [7:0] HALT_OPCODE = 8'hFF;
  localparam int         OPC_HI      = 23;
  localparam int         OPC_LO      = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// PC sequencer and fetch output stage between the combinational ROM and decode.
// Optional FETCH_STATS_EN adds a saturating 16-bit load counter (fetch_count).
module fetch_sequencer #(
  parameter int              PC_W     = fetch_pkg::DEFAULT_PC_W,
  parameter int              INSTR_W  = fetch_pkg::DEFAULT_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               halted
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]        fetch_count
`endif
);

  import fetch_pkg::*;

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [PC_W-1:0]    out_pc_q, out_pc_d;
  logic               load;

  // A redirect discards the word on instr_in, so it suppresses the load.
  assign load = (state_q == RUN) && (!out_valid_q || out_ready) && !redirect_valid;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;

    if (redirect_valid) begin
      pc_d        = redirect_target;
      out_valid_d = 1'b0;
      state_d     = RUN;
    end else begin
      case (state_q)
        IDLE: state_d = RUN;
        RUN: begin
          if (load) begin
            out_instr_d = instr_in;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + 1'b1;
            if (instr_in[OPC_HI:OPC_LO] == HALT_OPCODE) begin
              state_d = HALT;
            end
          end
        end
        HALT: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign pc        = pc_q;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign halted    = (state_q == HALT);

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_count_q;

  // Survives redirects; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
    end else if (load && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_q <= fetch_count_q + 16'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule
